// File: rtl/out_arb.sv
// out_arb: round-robin arbiter for one output port. Up to N_REQ input buffers
// compete for it, and the winning flit goes into a single registered output stage.
`ifndef PKT_W
`define PKT_W 32
`endif

module out_arb #(
  parameter int unsigned N_REQ  = 7,
  parameter int unsigned PYLD_W = `PKT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*PYLD_W-1:0] payload_i,
  output logic [N_REQ-1:0]        gnt,
  output logic                    obuf_rdy,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [PYLD_W-1:0]       out_payload
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N_REQ - 1);

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  hold_gnt_q, hold_gnt_d;
  logic              out_vld_q, out_vld_d;
  logic [PYLD_W-1:0] out_payload_q, out_payload_d;

  logic [N_REQ-1:0]  rr_gnt;
  logic [PTR_W-1:0]  gnt_idx;
  logic [PYLD_W-1:0] gnt_pyld;
  logic              xfer;

  // Round-robin search: the first requester at or above ptr wins, otherwise the first one below it.
  always_comb begin
    logic found;
    found  = 1'b0;
    rr_gnt = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req[i] && (i >= int'(ptr_q))) begin
        rr_gnt[i] = 1'b1;
        found     = 1'b1;
      end
    end
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!found && req[i] && (i < int'(ptr_q))) begin
        rr_gnt[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Grant output. While in HOLD the held grant is kept, masked by the live request bits.
  always_comb begin
    obuf_rdy = ~out_vld_q | out_rdy;
    gnt      = '0;
    if (!rst) begin
      gnt = (state_q == HOLD) ? (hold_gnt_q & req) : rr_gnt;
    end
  end

  // Encode the granted index and select that buffer's payload slice.
  always_comb begin
    gnt_idx  = '0;
    gnt_pyld = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (gnt[i]) begin
        gnt_idx  = PTR_W'(i);
        gnt_pyld = payload_i[i*PYLD_W +: PYLD_W];
      end
    end
  end

  assign xfer = (|gnt) & obuf_rdy;

  // Next-state logic for the FSM, the round-robin pointer and the output stage.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_gnt_d    = hold_gnt_q;
    out_vld_d     = out_vld_q;
    out_payload_d = out_payload_q;

    case (state_q)
      ARB: begin
        if ((|gnt) && !obuf_rdy) begin
          state_d    = HOLD;
          hold_gnt_d = gnt;
        end
      end
      HOLD: begin
        // Leave HOLD when the flit moves or when the held requester withdraws.
        if (xfer || !(|gnt)) begin
          state_d    = ARB;
          hold_gnt_d = '0;
        end
      end
      default: begin
        state_d    = ARB;
        hold_gnt_d = '0;
      end
    endcase

    if (xfer) begin
      ptr_d         = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + PTR_W'(1);
      out_vld_d     = 1'b1;
      out_payload_d = gnt_pyld;
    end else if (out_rdy) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB;
      ptr_q         <= '0;
      hold_gnt_q    <= '0;
      out_vld_q     <= 1'b0;
      out_payload_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_gnt_q    <= hold_gnt_d;
      out_vld_q     <= out_vld_d;
      out_payload_q <= out_payload_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_payload = out_payload_q;

  // Grant invariants: at most one bit set, and never to a buffer that is not requesting.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_gnt_subset : assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == '0);
  a_hold_stable : assert property (@(posedge clk) disable iff (rst)
                                   (out_vld && !out_rdy) |=> $stable(out_payload));

endmodule

// File: tb/tb_out_arb.sv
// tb_out_arb: random and directed stimulus for out_arb. A reference model queues the
// expected flits, and a separate monitor checks each flit when downstream accepts it.
module tb_out_arb;

  localparam int N = 7;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] payload_i = '0;
  logic [N-1:0]   gnt;
  logic           obuf_rdy;
  logic           out_vld;
  logic           out_rdy = 1'b0;
  logic [W-1:0]   out_payload;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];
  int m_ptr  = 0;
  int m_hold = -1;
  bit m_vld  = 1'b0;

  bit count_en = 1'b0;
  int grant_cnt[N];

  always #5 clk = ~clk;

  out_arb #(.N_REQ(N), .PYLD_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .payload_i  (payload_i),
    .gnt        (gnt),
    .obuf_rdy   (obuf_rdy),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_payload(out_payload)
  );

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input int p);
    logic [N-1:0] one;
    one = N'(1);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return one << ((p + k) % N);
    end
    return '0;
  endfunction

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs against the model, then advance the model.
  task automatic step(input logic [N-1:0] r, input logic rdy, input logic rs);
    logic [N-1:0] eg;
    logic [N-1:0] one;
    bit erdy;
    int g;
    one = N'(1);
    @(negedge clk);
    rst     = rs;
    req     = r;
    out_rdy = rdy;
    for (int i = 0; i < N; i++) payload_i[i*W +: W] = W'($urandom);
    #1;
    if (rs) begin
      check("gnt_in_reset", 32'(gnt), 32'd0);
      m_ptr  = 0;
      m_hold = -1;
      m_vld  = 1'b0;
      exp_q.delete();
    end else begin
      erdy = !m_vld || rdy;
      if (m_hold >= 0) eg = r[m_hold] ? (one << m_hold) : '0;
      else             eg = rr_pick(r, m_ptr);
      check("out_vld", 32'(out_vld), 32'(m_vld));
      check("obuf_rdy", 32'(obuf_rdy), 32'(erdy));
      check("gnt", 32'(gnt), 32'(eg));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("gnt_subset_req", 32'(gnt & ~r), 32'd0);
      if (count_en && obuf_rdy)
        for (int i = 0; i < N; i++) if (gnt[i]) grant_cnt[i]++;
      g = idx_of(eg);
      if (eg != '0 && erdy) begin
        exp_q.push_back(payload_i[g*W +: W]);
        m_ptr  = (g + 1) % N;
        m_hold = -1;
        m_vld  = 1'b1;
      end else begin
        if (m_hold >= 0 && eg == '0) m_hold = -1;
        else if (m_hold < 0 && eg != '0) m_hold = g;
        if (rdy) m_vld = 1'b0;
      end
    end
  endtask

  // Monitor: every accepted flit must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL pop_empty at %0t: got flit %0h expected none", $time, out_payload);
        end else begin
          check("out_payload", 32'(out_payload), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) grant_cnt[i] = 0;

    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);

    // Two requesters, downstream always ready.
    repeat (3) step(7'b0000101, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);

    // A blocked grant is held while a new request arrives.
    step(7'b0000010, 1'b0, 1'b0);
    step(7'b0001000, 1'b0, 1'b0);
    step(7'b0001001, 1'b0, 1'b0);
    step(7'b0001001, 1'b1, 1'b0);
    step(7'b0000001, 1'b1, 1'b0);

    // Pointer wraps from the last index back to 0.
    step(7'b0100000, 1'b1, 1'b0);
    step(7'b1000001, 1'b1, 1'b0);
    step(7'b1000001, 1'b1, 1'b0);

    // The held requester withdraws.
    step(7'b0000100, 1'b0, 1'b0);
    step(7'b0000000, 1'b0, 1'b0);
    step(7'b0000000, 1'b1, 1'b0);

    // Reset arrives while in HOLD with a valid flit.
    step(7'b0000100, 1'b0, 1'b0);
    step(7'b0000100, 1'b0, 1'b0);
    step(7'b1111111, 1'b0, 1'b1);
    step(7'b1111111, 1'b1, 1'b0);

    // Fairness with every requester active.
    count_en = 1'b1;
    repeat (14) step(7'b1111111, 1'b1, 1'b0);
    count_en = 1'b0;
    for (int i = 0; i < N; i++) check($sformatf("fair_cnt%0d", i), 32'(grant_cnt[i]), 32'd2);

    // Random traffic: requests mostly persist, so grants are frequently held.
    r = '0;
    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom) & N'($urandom);
      else if ($urandom_range(0, 2) == 0) r = r ^ (N'(1) << $urandom_range(0, N - 1));
      step(r, ($urandom_range(0, 99) < 55), ($urandom_range(0, 299) == 0));
    end

    repeat (3) step('0, 1'b1, 1'b0);
    check("drained_queue", 32'(exp_q.size()), 32'(m_vld));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/out_arb.md
OUT_ARB -- requirements
Module: out_arb

Interface
REQ-001 The module SHALL have parameter N_REQ, default 7, meaning the number of input buffers competing for this output port.
REQ-002 The module SHALL have parameter PYLD_W, default `PKT_W, meaning the payload width in bits.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port req, input, N_REQ bits: bit i is input buffer i's request for this output port.
REQ-006 The module SHALL have port payload_i, input, N_REQ*PYLD_W bits: slice i is input buffer i's payload.
REQ-007 The module SHALL have port gnt, output, N_REQ bits: a one-hot or all-zero grant to the input buffers.
REQ-008 The module SHALL have port obuf_rdy, output, 1 bit: the output register can accept a flit this cycle.
REQ-009 The module SHALL have port out_vld, output, 1 bit: the output register holds a valid flit.
REQ-010 The module SHALL have port out_rdy, input, 1 bit: the downstream consumer accepts the flit this cycle.
REQ-011 The module SHALL have port out_payload, output, PYLD_W bits: the registered payload.

Function
REQ-012 obuf_rdy SHALL be combinational: obuf_rdy = ~out_vld | out_rdy.
REQ-013 A transfer SHALL occur in any cycle where |gnt & obuf_rdy; input buffer i treats gnt[i] & obuf_rdy as its dequeue.
REQ-014 On a transfer, on the next edge: out_payload <= payload_i slice of the granted index, and out_vld <= 1.
REQ-015 If out_vld & out_rdy and no transfer occurs in the same cycle, out_vld SHALL go to 0 on the next edge.
REQ-016 Simultaneous drain and transfer SHALL keep out_vld=1 and load the new payload, giving full throughput of 1 flit per cycle.
REQ-017 The state machine SHALL have two states, ARB and HOLD.
REQ-018 In ARB, gnt SHALL be combinational round-robin over req, starting search at index ptr and wrapping from N_REQ-1 to 0; gnt=0 when req=0.
REQ-019 In ARB, if gnt≠0 and obuf_rdy=0, the FSM SHALL latch gnt into hold_gnt and go to HOLD.
REQ-020 In HOLD, gnt SHALL equal hold_gnt & req, regardless of newly arriving higher-priority requests.
REQ-021 HOLD SHALL return to ARB on transfer.
REQ-022 HOLD SHALL also return to ARB if the held request bit drops, with gnt=0 that cycle.
REQ-023 ptr (width clog2(N_REQ)) SHALL update only on a transfer, to (granted index + 1) mod N_REQ, so that N_REQ-1 wraps to 0.
REQ-024 gnt SHALL never have more than one bit set; the granted bit SHALL always have its req bit set.
REQ-025 Latency from req assertion, with the output empty, to out_vld SHALL be 1 cycle.
REQ-026 No transfer SHALL occur while obuf_rdy=0; out_payload SHALL be stable while out_vld=1 and out_rdy=0.

Reset
REQ-027 While rst=1, on each edge: out_vld=0, ptr=0, state=ARB, hold_gnt=0, out_payload=0.
REQ-028 During rst=1, gnt SHALL be forced to 0.
REQ-029 Reset asserted mid-HOLD or with out_vld=1 SHALL discard the held grant and the flit without transfer.
REQ-030 The first cycle after reset SHALL arbitrate from index 0.

Verification
REQ-031 Scenario 1: req=7'b0000101, out_rdy=1 every cycle -> gnt sequence 0000001, 0000100, 0000001; out_payload follows slices 0, 2, 0, one per cycle.
REQ-032 Scenario 2: out_vld=1, out_rdy=0, req=7'b0001000 -> gnt=0001000, obuf_rdy=0, FSM enters HOLD; req[0] then rises -> gnt stays 0001000; out_rdy=1 -> transfer of slice 3, ptr=4.
REQ-033 Scenario 3: ptr=6, req=7'b1000001 -> gnt=1000000; after transfer, ptr=0 and the next grant is 0000001 (wrap-around).
REQ-034 Scenario 4: in HOLD on index 2, req[2] drops -> gnt=0 that cycle, FSM returns to ARB, ptr unchanged, no out_payload update.
REQ-035 Scenario 5: rst=1 for one cycle while out_vld=1 in HOLD -> next cycle out_vld=0, gnt=0, ptr=0; req=7'b1111111 -> gnt=0000001.
REQ-036 Scenario 6: all 7 bits of req held for 14 cycles with out_rdy=1 -> each index granted exactly twice; assert gnt is one-hot/zero and gnt ⊆ req every cycle.
